// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
//   arb_state_t : arbiter FSM state (who owned the memory port last cycle)
//   owner_t     : tag of the read in flight, used to route iMemRData
//   NOP_INST    : instruction returned for a bad fetch address
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        LOCK  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LDRD  = 2'd2
    } owner_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/imem_rr_arb.sv
// Two-way grant logic for the instruction memory port.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   fetch_req_i      : CPU fetch request
//   ld_req_i         : loader request
//   ld_lock_i        : loader wants to keep the port on following cycles
//   fetch_gnt_o      : fetch owns the port this cycle (combinational)
//   ld_gnt_o         : loader owns the port this cycle (combinational)
// Contested cycles are decided round-robin on the last served requester,
// unless the loader holds a lock whose burst has not yet reached MAX_BURST.
module imem_rr_arb
    import imem_pkg::*;
#(
    parameter int unsigned MAX_BURST = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic fetch_req_i,
    input  logic ld_req_i,
    input  logic ld_lock_i,
    output logic fetch_gnt_o,
    output logic ld_gnt_o
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    arb_state_t     state_q, state_d;
    logic [CW-1:0]  burst_q, burst_d;
    logic           last_ld_q, last_ld_d;   // 1: loader was served last
    logic           burst_full;
    logic           lock_hold;

    always_comb begin
        fetch_gnt_o = 1'b0;
        ld_gnt_o    = 1'b0;
        state_d     = IDLE;
        burst_d     = '0;
        last_ld_d   = last_ld_q;

        burst_full = (burst_q == CW'(MAX_BURST));
        // The lock only beats round-robin while the loader still asks for it
        // and its burst budget is not used up.
        lock_hold  = (state_q == LOCK) && ld_lock_i && !burst_full;

        // No grants while reset is applied so nothing new goes in flight.
        if (!rst_i) begin
            if (fetch_req_i && ld_req_i) begin
                if (lock_hold || !last_ld_q) begin
                    ld_gnt_o = 1'b1;
                end else begin
                    fetch_gnt_o = 1'b1;
                end
            end else begin
                fetch_gnt_o = fetch_req_i;
                ld_gnt_o    = ld_req_i;
            end
        end

        if (fetch_gnt_o) begin
            state_d   = FETCH;
            last_ld_d = 1'b0;
        end else if (ld_gnt_o) begin
            state_d   = ld_lock_i ? LOCK : LOAD;
            last_ld_d = 1'b1;
        end

        // Counts locked loader grants; leaving LOCK or any fetch grant clears it.
        if (ld_gnt_o && ld_lock_i) begin
            burst_d = burst_full ? burst_q : burst_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            burst_q   <= '0;
            last_ld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            last_ld_q <= last_ld_d;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares a single-port, 1-cycle synchronous-read instruction memory between
// the CPU fetch port and a loader/debug port.
//   iCLK, iRST                    : clock, synchronous active-high reset
//   iFetchReq/iFetchAddr          : fetch request, byte address
//   oFetchInst/oFetchValid/oFetchErr : fetch response one cycle after grant
//   oFetchStall                   : fetch request not accepted this cycle
//   iLdReq/iLdWe/iLdLock/iLdAddr/iLdWData : loader access request
//   oLdGnt                        : loader access accepted this cycle
//   oLdRData/oLdRValid            : loader read response one cycle after grant
//   oMemAddr/oMemWData/oMemWe     : memory port, iMemRData returned next cycle
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned MAX_BURST = 8,
    parameter logic [31:0] NOP_INST  = imem_pkg::NOP_INST
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     iFetchReq,
    input  logic [31:0]              iFetchAddr,
    output logic [31:0]              oFetchInst,
    output logic                     oFetchValid,
    output logic                     oFetchErr,
    output logic                     oFetchStall,
    input  logic                     iLdReq,
    input  logic                     iLdWe,
    input  logic                     iLdLock,
    input  logic [31:0]              iLdAddr,
    input  logic [31:0]              iLdWData,
    output logic                     oLdGnt,
    output logic [31:0]              oLdRData,
    output logic                     oLdRValid,
    output logic [$clog2(DEPTH)-1:0] oMemAddr,
    output logic [31:0]              oMemWData,
    output logic                     oMemWe,
    input  logic [31:0]              iMemRData
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic           fetch_gnt, ld_gnt;
    logic           fetch_err;
    owner_t         owner_q, owner_d;
    logic           ferr_q, ferr_d;
    logic [31:0]    finst_q, ldrdata_q;
    logic [AW-1:0]  mem_addr_q;
    logic           unused_ld_addr;

    assign unused_ld_addr = ^{iLdAddr[31:AW+2], iLdAddr[1:0]};

    imem_rr_arb #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk_i       (iCLK),
        .rst_i       (iRST),
        .fetch_req_i (iFetchReq),
        .ld_req_i    (iLdReq),
        .ld_lock_i   (iLdLock),
        .fetch_gnt_o (fetch_gnt),
        .ld_gnt_o    (ld_gnt)
    );

    assign fetch_err   = (iFetchAddr[1:0] != 2'b00) || (iFetchAddr >= 32'(4 * DEPTH));
    assign oFetchStall = iFetchReq & ~fetch_gnt;
    assign oLdGnt      = iLdReq & ld_gnt;

    // A granted but faulting fetch leaves the memory port untouched.
    always_comb begin
        oMemAddr  = mem_addr_q;
        oMemWData = iLdWData;
        oMemWe    = 1'b0;
        owner_d   = OWN_NONE;
        ferr_d    = 1'b0;
        if (fetch_gnt) begin
            owner_d = OWN_FETCH;
            ferr_d  = fetch_err;
            if (!fetch_err) begin
                oMemAddr = iFetchAddr[AW+1:2];
            end
        end else if (ld_gnt) begin
            oMemAddr = iLdAddr[AW+1:2];
            oMemWe   = iLdWe;
            owner_d  = iLdWe ? OWN_NONE : OWN_LDRD;
        end
    end

    // Responses are formed from the tag registered at grant and the memory
    // data arriving now; the hold registers keep the last shown word.
    always_comb begin
        oFetchValid = (owner_q == OWN_FETCH);
        oFetchErr   = oFetchValid & ferr_q;
        oLdRValid   = (owner_q == OWN_LDRD);
        oFetchInst  = finst_q;
        oLdRData    = ldrdata_q;
        if (oFetchValid) begin
            oFetchInst = ferr_q ? NOP_INST : iMemRData;
        end
        if (oLdRValid) begin
            oLdRData = iMemRData;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            owner_q    <= OWN_NONE;
            ferr_q     <= 1'b0;
            finst_q    <= '0;
            ldrdata_q  <= '0;
            mem_addr_q <= '0;
        end else begin
            owner_q    <= owner_d;
            ferr_q     <= ferr_d;
            finst_q    <= oFetchInst;
            ldrdata_q  <= oLdRData;
            mem_addr_q <= oMemAddr;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;
    import imem_pkg::*;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iFetchReq;
    logic [31:0] iFetchAddr;
    logic [31:0] oFetchInst;
    logic        oFetchValid, oFetchErr, oFetchStall;
    logic        iLdReq, iLdWe, iLdLock;
    logic [31:0] iLdAddr, iLdWData;
    logic        oLdGnt;
    logic [31:0] oLdRData;
    logic        oLdRValid;
    logic [7:0]  oMemAddr;
    logic [31:0] oMemWData;
    logic        oMemWe;
    logic [31:0] iMemRData;

    imem_arbiter #(
        .DEPTH     (256),
        .MAX_BURST (8),
        .NOP_INST  (32'h0000_0013)
    ) dut (
        .iCLK        (iCLK),
        .iRST        (iRST),
        .iFetchReq   (iFetchReq),
        .iFetchAddr  (iFetchAddr),
        .oFetchInst  (oFetchInst),
        .oFetchValid (oFetchValid),
        .oFetchErr   (oFetchErr),
        .oFetchStall (oFetchStall),
        .iLdReq      (iLdReq),
        .iLdWe       (iLdWe),
        .iLdLock     (iLdLock),
        .iLdAddr     (iLdAddr),
        .iLdWData    (iLdWData),
        .oLdGnt      (oLdGnt),
        .oLdRData    (oLdRData),
        .oLdRValid   (oLdRValid),
        .oMemAddr    (oMemAddr),
        .oMemWData   (oMemWData),
        .oMemWe      (oMemWe),
        .iMemRData   (iMemRData)
    );

    always #5 iCLK = ~iCLK;

    // 1-cycle synchronous-read memory, preloaded with 0xC0000000 + index
    logic [31:0] mem [256];
    always @(posedge iCLK) begin
        if (oMemWe) mem[oMemAddr] <= oMemWData;
        iMemRData <= mem[oMemAddr];
    end

    logic [32:0] fq[$];   // {err, inst}
    logic [32:0] lq[$];   // {0, rdata}
    int n_cmp = 0;
    int n_mis = 0;
    int wr_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response
    always @(negedge iCLK) begin
        logic [32:0] e;
        if (oMemWe === 1'b1) wr_cnt++;
        if (oFetchValid === 1'b1) begin
            if (fq.size() == 0) begin
                check("fetch unexpected valid", 32'd1, 32'd0);
            end else begin
                e = fq.pop_front();
                check("fetch inst", oFetchInst, e[31:0]);
                check("fetch err", 32'(oFetchErr), 32'(e[32]));
            end
        end
        if (oLdRValid === 1'b1) begin
            if (lq.size() == 0) begin
                check("ld unexpected valid", 32'd1, 32'd0);
            end else begin
                e = lq.pop_front();
                check("ld rdata", oLdRData, e[31:0]);
            end
        end
    end

    task automatic drv(input bit fr, input logic [31:0] fa, input bit lr, input bit lw,
                       input bit lk, input logic [31:0] la, input logic [31:0] ldat);
        iFetchReq  = fr;
        iFetchAddr = fa;
        iLdReq     = lr;
        iLdWe      = lw;
        iLdLock    = lk;
        iLdAddr    = la;
        iLdWData   = ldat;
    endtask

    // eg: expected grant 0=none 1=fetch 2=loader; exp_addr<0 skips address check
    task automatic step(input string nm, input int eg, input bit push,
                        input logic [32:0] er, input int exp_addr);
        @(negedge iCLK);
        check({nm, " stall"}, 32'(oFetchStall), 32'(iFetchReq && eg != 1));
        check({nm, " ldgnt"}, 32'(oLdGnt), 32'(eg == 2));
        check({nm, " we"}, 32'(oMemWe), 32'(eg == 2 && iLdWe));
        if (exp_addr >= 0) check({nm, " maddr"}, 32'(oMemAddr), exp_addr);
        if (push) begin
            if (eg == 1) fq.push_back(er);
            else lq.push_back(er);
        end
        @(posedge iCLK); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC000_0000 + 32'(i);
        drv(0, 0, 0, 0, 0, 0, 0);
        iRST = 1'b1;
        repeat (2) @(posedge iCLK);
        #1 iRST = 1'b0;

        // reset state
        @(negedge iCLK);
        check("rst fvalid", 32'(oFetchValid), 32'd0);
        check("rst lvalid", 32'(oLdRValid), 32'd0);
        check("rst finst", oFetchInst, 32'd0);
        check("rst lrdata", oLdRData, 32'd0);
        check("rst maddr", 32'(oMemAddr), 32'd0);
        check("rst state", 32'(dut.u_arb.state_q), 32'(IDLE));
        @(posedge iCLK); #1;

        // fetch only, consecutive words
        drv(1, 32'h0, 0, 0, 0, 0, 0); step("f0", 1, 1, {1'b0, 32'hC000_0000}, 0);
        drv(1, 32'h4, 0, 0, 0, 0, 0); step("f4", 1, 1, {1'b0, 32'hC000_0001}, 1);
        drv(1, 32'h8, 0, 0, 0, 0, 0); step("f8", 1, 1, {1'b0, 32'hC000_0002}, 2);
        drv(0, 0, 0, 0, 0, 0, 0);     step("idle1", 0, 0, '0, 2);

        // both requesting, no lock: L,F,L,F
        drv(1, 32'h20, 1, 0, 0, 32'h40, 0); step("rr a", 2, 1, {1'b0, 32'hC000_0010}, 16);
        drv(1, 32'h20, 1, 0, 0, 32'h44, 0); step("rr b", 1, 1, {1'b0, 32'hC000_0008}, 8);
        drv(1, 32'h24, 1, 0, 0, 32'h44, 0); step("rr c", 2, 1, {1'b0, 32'hC000_0011}, 17);
        drv(1, 32'h24, 1, 0, 0, 32'h48, 0); step("rr d", 1, 1, {1'b0, 32'hC000_0009}, 9);
        drv(0, 0, 0, 0, 0, 0, 0);           step("idle2", 0, 0, '0, 9);

        // locked loader burst with fetch waiting: 8 loader grants, then fetch
        for (int k = 0; k < 8; k++) begin
            drv(1, 32'h30, 1, 0, 1, 32'h80 + 32'(4 * k), 0);
            step("burst", 2, 1, {1'b0, 32'hC000_0020 + 32'(k)}, 32 + k);
        end
        drv(1, 32'h30, 1, 0, 1, 32'hA0, 0); step("burst end", 1, 1, {1'b0, 32'hC000_000C}, 12);
        drv(0, 0, 0, 0, 0, 0, 0);           step("idle3", 0, 0, '0, 12);

        // bad fetch addresses: NOP with error, memory port untouched
        drv(1, 32'h2, 0, 0, 0, 0, 0);   step("ferr 0x2", 1, 1, {1'b1, 32'h0000_0013}, 12);
        drv(1, 32'h400, 0, 0, 0, 0, 0); step("ferr 0x400", 1, 1, {1'b1, 32'h0000_0013}, 12);
        drv(0, 0, 0, 0, 0, 0, 0);       step("idle4", 0, 0, '0, 12);

        // loader write then fetch it back
        drv(0, 0, 1, 1, 0, 32'h10, 32'h00A0_0093); step("ld wr", 2, 0, '0, 4);
        drv(1, 32'h10, 0, 0, 0, 0, 0);             step("rdback", 1, 1, {1'b0, 32'h00A0_0093}, 4);
        drv(0, 0, 0, 0, 0, 0, 0);                  step("idle5", 0, 0, '0, 4);

        // reset during LOCK with a loader read in flight
        drv(0, 0, 1, 0, 1, 32'h0, 0); step("lock rd", 2, 1, {1'b0, 32'hC000_0000}, 0);
        iRST = 1'b1;
        @(negedge iCLK);
        check("pre-rst state", 32'(dut.u_arb.state_q), 32'(LOCK));
        @(posedge iCLK); #1;
        iRST = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge iCLK);
        check("post-rst lvalid", 32'(oLdRValid), 32'd0);
        check("post-rst fvalid", 32'(oFetchValid), 32'd0);
        check("post-rst state", 32'(dut.u_arb.state_q), 32'(IDLE));
        @(posedge iCLK); #1;

        repeat (2) @(posedge iCLK);
        #1;
        check("fetch queue drained", 32'(fq.size()), 32'd0);
        check("ld queue drained", 32'(lq.size()), 32'd0);
        check("write pulses", 32'(wr_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
